chk_stimul: RTL and testbench
=============================

# chk_stimul

Synchronous response checker for the parametrizable stimulus generator's counting sequence. It receives an NO_OUT-bit value per valid cycle and compares it against an internal expected counter starting at 0. It counts matches and mismatches and reports pass/fail once all 2^NO_OUT values have been consumed. It sits at the receive end of lab testbenches, replacing manual waveform inspection with a registered verdict.

## Interface
- NO_OUT, 4, width of checked data; a full run is 2^NO_OUT samples
- ERR_W, 8, width of the saturating error and match counters
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  synchronous run start/restart pulse
- stimul_valid  input  1  stimul carries a sample this cycle
- stimul  input  NO_OUT  sample under check
- expected  output  NO_OUT  value the next sample must equal
- busy  output  1  high while in CHECK
- error  output  1  one-cycle pulse per detected mismatch
- err_cnt  output  ERR_W  mismatches in current run, saturating
- match_cnt  output  ERR_W  matches in current run, saturating
- done  output  1  run complete, held until start or reset
- pass  output  1  valid only with done: 1 iff err_cnt == 0

## Operation
- States: IDLE, CHECK, DONE. Reset state is IDLE.
- IDLE
  - Samples are ignored.
  - start -> CHECK; expected, err_cnt, match_cnt and the sample counter are cleared.
- CHECK, on each cycle with stimul_valid = 1:
  - Compare stimul with expected.
  - Equal: match_cnt + 1.
  - Unequal: err_cnt + 1 and error pulses.
  - expected <= expected + 1 modulo 2^NO_OUT in both cases. There is no resynchronisation to the received value.
  - Sample counter (NO_OUT+1 bits) increments.
- Sample counter reaching 2^NO_OUT -> DONE.
- Cycles with stimul_valid = 0 in CHECK change nothing.
- DONE
  - done = 1 and pass = (err_cnt == 0), both held.
  - Samples are ignored.
  - start -> CHECK with a full clear.
- start in CHECK restarts: full clear, remain in CHECK.
- start and stimul_valid in the same cycle: start wins and the sample is discarded.
- Counters saturate at 2^ERR_W-1 and never wrap.
- expected wraps from 2^NO_OUT-1 to 0. On a normal run this coincides with entry to DONE.
- Reset (rst_n low, any time, including mid-run): immediately
  - state = IDLE
  - expected = 0, err_cnt = 0, match_cnt = 0
  - error = 0, done = 0, pass = 0, busy = 0

## Timing
- All outputs are registered. No combinational input-to-output path.
- A sample accepted on edge N updates expected, err_cnt, match_cnt and error at edge N (visible after N).
- error is high for exactly one cycle per mismatched sample. Consecutive mismatches keep it high continuously.
- The last sample accepted on edge N gives done = 1 and busy = 0 after edge N. pass is valid in the same cycle.
- busy rises the cycle after the start edge and falls with done.
- A start accepted on edge N clears done/pass and raises busy after edge N.
- Throughput: one sample per cycle; back-to-back valid is supported.
- Reset assertion is asynchronous. Deassertion must be synchronised externally to clk.

## Test plan
- NO_OUT=4, start, then values 0..15 on 16 consecutive valid cycles -> match_cnt=16, err_cnt=0, error never high, done=1 and pass=1 right after the 16th edge, expected=0.
- Same stream with sample 5 driven as 9 -> exactly one error pulse, the cycle after sample 5; err_cnt=1, match_cnt=15, done=1, pass=0.
- Valid cycles separated by random gaps of 0-3 idle cycles -> identical counters to the gapless run; expected holds during gaps.
- Start asserted after 7 samples, coincident with a valid sample -> that sample is dropped, counters 0, expected=0; a fresh 0..15 run then passes.
- rst_n pulsed low mid-run (after 10 samples, asynchronously between edges) -> all outputs 0 immediately, state IDLE, subsequent samples ignored until start.
- ERR_W=2 with 16 wrong samples -> err_cnt saturates at 3, error high for all 16 cycles, pass=0.

Source files
------------

// File: rtl/chk_stimul.sv
// chk_stimul: receive-side checker for a counting stimulus stream.
// Each valid sample is compared against an internal counter that starts at 0
// and advances once per accepted sample. Matches and mismatches are counted
// with saturation. A registered pass/fail verdict is raised once 2^NO_OUT
// samples have been consumed.
module chk_stimul #(
  parameter int NO_OUT = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stimul_valid,
  input  logic [NO_OUT-1:0] stimul,
  output logic [NO_OUT-1:0] expected,
  output logic              busy,
  output logic              error,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ERR_W-1:0]  match_cnt,
  output logic              done,
  output logic              pass
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // One full run is 2^NO_OUT samples; the sample counter is one bit wider
  // so that the terminal count is representable.
  localparam logic [NO_OUT:0]  RUN_LEN = {1'b1, {NO_OUT{1'b0}}};
  localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};

  logic [1:0]        state_q,     state_d;
  logic [NO_OUT-1:0] expected_q,  expected_d;
  logic [ERR_W-1:0]  err_cnt_q,   err_cnt_d;
  logic [ERR_W-1:0]  match_cnt_q, match_cnt_d;
  logic [NO_OUT:0]   smp_cnt_q,   smp_cnt_d;
  logic              error_q,     error_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              pass_q,      pass_d;

  // Counters stick at their maximum instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Next-state logic: start from any state forces a clean run; samples are
  // only consumed in CHECK, and start wins over a coincident sample.
  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    err_cnt_d   = err_cnt_q;
    match_cnt_d = match_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    error_d     = 1'b0;

    if (start) begin
      state_d     = S_CHECK;
      expected_d  = '0;
      err_cnt_d   = '0;
      match_cnt_d = '0;
      smp_cnt_d   = '0;
    end else begin
      case (state_q)
        S_CHECK: begin
          if (stimul_valid) begin
            if (stimul == expected_q) begin
              match_cnt_d = sat_inc(match_cnt_q);
            end else begin
              err_cnt_d = sat_inc(err_cnt_q);
              error_d   = 1'b1;
            end
            // No resynchronisation: expected always steps by one and wraps.
            expected_d = expected_q + 1'b1;
            smp_cnt_d  = smp_cnt_q + 1'b1;
            if (smp_cnt_d == RUN_LEN) begin
              state_d = S_DONE;
            end
          end
        end
        S_IDLE, S_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_cnt_d == '0);
  end

  // State and output registers; reset returns everything to an idle, cleared checker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      expected_q  <= '0;
      err_cnt_q   <= '0;
      match_cnt_q <= '0;
      smp_cnt_q   <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      err_cnt_q   <= err_cnt_d;
      match_cnt_q <= match_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign expected  = expected_q;
  assign busy      = busy_q;
  assign error     = error_q;
  assign err_cnt   = err_cnt_q;
  assign match_cnt = match_cnt_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_chk_stimul.sv
// tb_chk_stimul: table-driven vectors plus a reference model feeding a
// scoreboard queue. A second instance with ERR_W=2 shares the stimulus and
// is inspected only in the saturation sequence.
module tb_chk_stimul;

  localparam int NO_OUT = 4;
  localparam int ERR_W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, stimul_valid;
  logic [NO_OUT-1:0] stimul;

  logic [NO_OUT-1:0] exp_a, exp_b;
  logic              busy_a, error_a, done_a, pass_a;
  logic              busy_b, error_b, done_b, pass_b;
  logic [ERR_W-1:0]  ecnt_a, mcnt_a;
  logic [1:0]        ecnt_b, mcnt_b;

  chk_stimul #(.NO_OUT(NO_OUT), .ERR_W(ERR_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stimul_valid(stimul_valid),
    .stimul(stimul), .expected(exp_a), .busy(busy_a), .error(error_a),
    .err_cnt(ecnt_a), .match_cnt(mcnt_a), .done(done_a), .pass(pass_a));

  chk_stimul #(.NO_OUT(NO_OUT), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stimul_valid(stimul_valid),
    .stimul(stimul), .expected(exp_b), .busy(busy_b), .error(error_b),
    .err_cnt(ecnt_b), .match_cnt(mcnt_b), .done(done_b), .pass(pass_b));

  typedef struct {
    logic             s;
    logic             v;
    logic [3:0]       d;
    logic [3:0]       e_exp;
    logic             e_busy;
    logic             e_err;
    logic [ERR_W-1:0] e_ecnt;
    logic [ERR_W-1:0] e_mcnt;
    logic             e_done;
    logic             e_pass;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state (unsaturated counts, state as 0=idle 1=check 2=done)
  int m_st, m_exp, m_e, m_m, m_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic s, v, input logic [3:0] d, input int ex,
                              input logic b, er, input int ec, mc, input logic dn, ps);
    vec_t r;
    r.s = s; r.v = v; r.d = d; r.e_exp = 4'(ex); r.e_busy = b; r.e_err = er;
    r.e_ecnt = ERR_W'(ec); r.e_mcnt = ERR_W'(mc); r.e_done = dn; r.e_pass = ps;
    return r;
  endfunction

  task automatic compare_now(input vec_t e, input string tag);
    chk({tag, "/expected"},  32'(exp_a),   32'(e.e_exp));
    chk({tag, "/busy"},      32'(busy_a),  32'(e.e_busy));
    chk({tag, "/error"},     32'(error_a), 32'(e.e_err));
    chk({tag, "/err_cnt"},   32'(ecnt_a),  32'(e.e_ecnt));
    chk({tag, "/match_cnt"}, 32'(mcnt_a),  32'(e.e_mcnt));
    chk({tag, "/done"},      32'(done_a),  32'(e.e_done));
    chk({tag, "/pass"},      32'(pass_a),  32'(e.e_pass));
  endtask

  // Drive one cycle, queue its expectation, then check after the edge.
  task automatic apply(input vec_t r, input string tag);
    vec_t e;
    @(negedge clk);
    start = r.s; stimul_valid = r.v; stimul = r.d;
    sb_q.push_back(r);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "/scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      compare_now(e, tag);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_exp = 0; m_e = 0; m_m = 0; m_n = 0;
  endtask

  task automatic model_step(input logic s, v, input logic [3:0] d, output vec_t r);
    logic err;
    err = 1'b0;
    if (s) begin
      m_st = 1; m_exp = 0; m_e = 0; m_m = 0; m_n = 0;
    end else if (m_st == 1 && v) begin
      if (int'(d) == m_exp) m_m++;
      else begin
        m_e++;
        err = 1'b1;
      end
      m_exp = (m_exp + 1) % 16;
      m_n++;
      if (m_n == 16) m_st = 2;
    end
    r = mk(s, v, d, m_exp, m_st == 1, err, (m_e > 255) ? 255 : m_e,
           (m_m > 255) ? 255 : m_m, m_st == 2, (m_st == 2) && (m_e == 0));
  endtask

  task automatic drive_model(input logic s, v, input logic [3:0] d, input string tag);
    vec_t r;
    model_step(s, v, d, r);
    apply(r, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t z, dummy;
    int   sat;

    // ---- table: clean run, a sample in DONE, then a run with sample 5 corrupted
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(0, 1, 4'(i), (i + 1) % 16, i < 15, 0, 0, i + 1, i == 15, i == 15));
    tbl.push_back(mk(0, 1, 4'd3, 0, 0, 0, 0, 16, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(0, 1, (i == 5) ? 4'd9 : 4'(i), (i + 1) % 16, i < 15, i == 5,
                       (i >= 5) ? 1 : 0, i + 1 - ((i >= 5) ? 1 : 0), i == 15, 0));

    // ---- reset state
    rst_n = 1'b0; start = 1'b0; stimul_valid = 1'b0; stimul = '0;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    compare_now(z, "reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // samples before any start are ignored
    for (int i = 0; i < 2; i++) drive_model(0, 1, 4'(i), "idle_ignore");

    foreach (tbl[k]) begin
      model_step(tbl[k].s, tbl[k].v, tbl[k].d, dummy);
      apply(tbl[k], $sformatf("tbl%0d", k));
    end

    // ---- random gaps of 0-3 idle cycles between samples
    drive_model(1, 0, 0, "gap_start");
    for (int i = 0; i < 16; i++) begin
      int g;
      g = $urandom_range(0, 3);
      for (int j = 0; j < g; j++) drive_model(0, 0, 4'($urandom_range(0, 15)), "gap_idle");
      drive_model(0, 1, 4'(i), "gap_sample");
    end
    chk("gap_final_match", 32'(mcnt_a), 32'd16);
    chk("gap_final_pass",  32'(pass_a), 32'd1);

    // ---- restart coincident with a valid sample after 7 samples
    drive_model(1, 0, 0, "rs_start");
    for (int i = 0; i < 7; i++) drive_model(0, 1, 4'(i), "rs_pre");
    drive_model(1, 1, 4'd7, "rs_collide");
    chk("rs_collide_expected", 32'(exp_a), 32'd0);
    for (int i = 0; i < 16; i++) drive_model(0, 1, 4'(i), "rs_run");
    chk("rs_final_pass", 32'(pass_a), 32'd1);

    // ---- asynchronous reset mid-run after 10 samples
    drive_model(1, 0, 0, "ar_start");
    for (int i = 0; i < 10; i++) drive_model(0, 1, 4'(i), "ar_pre");
    @(negedge clk);
    start = 1'b0; stimul_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    compare_now(z, "async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 10; i < 13; i++) drive_model(0, 1, 4'(i), "ar_after");

    // ---- 16 wrong samples: ERR_W=2 instance saturates at 3
    drive_model(1, 0, 0, "sat_start");
    chk("sat_start_ecnt_b", 32'(ecnt_b), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive_model(0, 1, 4'((i + 1) % 16), "sat_run");
      sat = (i + 1 > 3) ? 3 : i + 1;
      chk($sformatf("sat_error_b%0d", i), 32'(error_b), 32'd1);
      chk($sformatf("sat_ecnt_b%0d", i),  32'(ecnt_b),  32'(sat));
    end
    chk("sat_mcnt_b", 32'(mcnt_b), 32'd0);
    chk("sat_done_b", 32'(done_b), 32'd1);
    chk("sat_pass_b", 32'(pass_b), 32'd0);
    chk("sat_ecnt_a", 32'(ecnt_a), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
